// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the FIFO-fronted UART transmitter.
// The producer holds the master modport; the transmitter holds the slave modport.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]              data_in;
  logic                              tx_start;
  logic                              tx_ready;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              tx;
  logic                              tx_busy;
  logic                              tx_done;

  modport master (output data_in, tx_start,
                  input  tx_ready, fifo_count, tx, tx_busy, tx_done);
  modport slave  (input  data_in, tx_start,
                  output tx_ready, fifo_count, tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a configurable frame format.
// Frames are sent back to back while the FIFO holds data.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, full, empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.tx_start && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Transmit FSM
  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [NW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par_q, par_n, tx_q, tx_n, done_q, done_n;
  logic                 bit_end, load;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign head     = mem[rd_ptr];
  assign head_par = (^head) ^ (PARITY == 2);
  assign bit_end  = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bcnt_n  = bcnt;
    sh_n    = sh;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    if (state != S_IDLE) baud_n = bit_end ? '0 : baud + 1'b1;
    case (state)
      S_IDLE: if (!empty) load = 1'b1;
      S_START: if (bit_end) begin
        state_n = S_DATA;
        tx_n    = sh[0];
        sh_n    = sh >> 1;
        bcnt_n  = '0;
      end
      S_DATA: if (bit_end) begin
        if (bcnt == DATA_LAST) begin
          bcnt_n = '0;
          if (PARITY != 0) begin
            state_n = S_PAR;
            tx_n    = par_q;
          end else begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 1'b1;
          tx_n   = sh[0];
          sh_n   = sh >> 1;
        end
      end
      S_PAR: if (bit_end) begin
        state_n = S_STOP;
        tx_n    = 1'b1;
        bcnt_n  = '0;
      end
      S_STOP: if (bit_end) begin
        if (bcnt == STOP_LAST) begin
          done_n = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) load = 1'b1;
          else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_n = S_START;
      sh_n    = head;
      par_n   = head_par;
      tx_n    = 1'b0;
      baud_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      baud   <= '0;
      bcnt   <= '0;
      sh     <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bcnt   <= bcnt_n;
      sh     <= sh_n;
      par_q  <= par_n;
      tx_q   <= tx_n;
      done_q <= done_n;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_busy    = (state != S_IDLE);
  assign bus.tx_ready   = !full;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo across several frame formats.
// Line monitors decode frames and compare them against queued expectations.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int NI = 5;
  localparam int B  = 4;                   // burst/random instance, 8N1 at 8 clocks per bit
  localparam int FRAME_B = (1 + 8 + 1) * 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [8:0] din_r   [NI];
  logic       start_r [NI];
  logic       tx_w [NI], busy_w [NI], done_w [NI], rdy_w [NI];
  logic [2:0] cnt_w [NI];

  int         errors = 0, checks = 0;
  logic [8:0] exp_q [NI][$];
  int         exp_tot [NI], done_cnt [NI], idle_bad [NI];

  // Abstract model of instance B: a word queue plus cycles left on the line.
  logic [8:0] mq[$];
  int         m_rem;
  bit         m_done, m_pop;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if3 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if4 ();

  uart_tx_fifo #(.CLK_FREQ(12000000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_def (.clk(clk), .reset(reset), .bus(if0.slave));
  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(2), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_even (.clk(clk), .reset(reset), .bus(if1.slave));
  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_odd (.clk(clk), .reset(reset), .bus(if2.slave));
  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_nar (.clk(clk), .reset(reset), .bus(if3.slave));
  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_bur (.clk(clk), .reset(reset), .bus(if4.slave));

  assign if0.data_in = din_r[0][7:0]; assign if0.tx_start = start_r[0];
  assign if1.data_in = din_r[1][7:0]; assign if1.tx_start = start_r[1];
  assign if2.data_in = din_r[2][7:0]; assign if2.tx_start = start_r[2];
  assign if3.data_in = din_r[3][6:0]; assign if3.tx_start = start_r[3];
  assign if4.data_in = din_r[4][7:0]; assign if4.tx_start = start_r[4];
  assign tx_w[0] = if0.tx; assign busy_w[0] = if0.tx_busy; assign done_w[0] = if0.tx_done; assign rdy_w[0] = if0.tx_ready; assign cnt_w[0] = if0.fifo_count;
  assign tx_w[1] = if1.tx; assign busy_w[1] = if1.tx_busy; assign done_w[1] = if1.tx_done; assign rdy_w[1] = if1.tx_ready; assign cnt_w[1] = if1.fifo_count;
  assign tx_w[2] = if2.tx; assign busy_w[2] = if2.tx_busy; assign done_w[2] = if2.tx_done; assign rdy_w[2] = if2.tx_ready; assign cnt_w[2] = if2.fifo_count;
  assign tx_w[3] = if3.tx; assign busy_w[3] = if3.tx_busy; assign done_w[3] = if3.tx_done; assign rdy_w[3] = if3.tx_ready; assign cnt_w[3] = if3.fifo_count;
  assign tx_w[4] = if4.tx; assign busy_w[4] = if4.tx_busy; assign done_w[4] = if4.tx_done; assign rdy_w[4] = if4.tx_ready; assign cnt_w[4] = if4.fifo_count;

  function automatic int cpb(input int k);
    case (k)
      0:       return 1250;
      1, 2:    return 4;
      3:       return 16;
      default: return 8;
    endcase
  endfunction
  function automatic int db(input int k);  return (k == 3) ? 7 : 8; endfunction
  function automatic int par(input int k); return (k == 1 || k == 3) ? 1 : (k == 2) ? 2 : 0; endfunction
  function automatic int sb(input int k);  return (k == 3) ? 2 : 1; endfunction
  function automatic int nbits(input int k);
    return 1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k);
  endfunction

  // Bit i of the result is the i-th bit on the line; unused upper bits read as 1.
  function automatic logic [15:0] frame(input int k, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < db(k); i++) begin
      f[1+i] = d[i];
      p ^= d[i];
    end
    if (par(k) != 0) f[1+db(k)] = (par(k) == 2) ? ~p : p;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n, inout bit ab);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  task automatic mon(input int k);
    logic [15:0] obs;
    logic [8:0]  w;
    bit          ab;
    int          n;
    forever begin
      @(negedge clk);
      if (reset || tx_w[k] !== 1'b0) continue;
      n   = nbits(k);
      obs = '1;
      ab  = 1'b0;
      wait_cyc(cpb(k) / 2, ab);
      for (int b = 0; b < n && !ab; b++) begin
        obs[b] = tx_w[k];
        if (b < n - 1) wait_cyc(cpb(k), ab);
      end
      if (ab) continue;
      if (exp_q[k].size() == 0) begin
        checks++; errors++;
        $display("FAIL frame%0d: unexpected frame bits %h at %0t", k, obs, $time);
      end else begin
        w = exp_q[k].pop_front();
        chk($sformatf("frame%0d data %02h", k, w), 32'(obs), 32'(frame(k, w)));
      end
    end
  endtask

  initial fork
    mon(0); mon(1); mon(2); mon(3); mon(4);
  join

  initial begin
    bit prev [NI];
    for (int k = 0; k < NI; k++) prev[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (done_w[k] && !reset) begin
          done_cnt[k]++;
          chk($sformatf("done%0d single cycle", k), 32'(prev[k]), 32'd0);
        end
        prev[k] = done_w[k];
      end
    end
  end

  initial begin
    bit ending, pop_now, push_now;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_rem = 0; m_done = 1'b0; m_pop = 1'b0;
      end else begin
        ending   = (m_rem == 1);
        pop_now  = (ending || m_rem == 0) && mq.size() > 0;
        push_now = start_r[B] && mq.size() < 4;
        m_done   = ending;
        m_pop    = pop_now;
        if (pop_now) begin
          void'(mq.pop_front());
          m_rem = FRAME_B;
        end else if (m_rem > 0) m_rem--;
        if (push_now) begin
          mq.push_back(din_r[B]);
          exp_q[B].push_back(din_r[B] & 9'h0FF);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("b fifo_count", 32'(cnt_w[B]), 32'(mq.size()));
      chk("b tx_ready",   32'(rdy_w[B]), 32'(mq.size() < 4));
      chk("b tx_busy",    32'(busy_w[B]), 32'(m_rem > 0));
      chk("b tx_done",    32'(done_w[B]), 32'(m_done));
      if (m_pop) chk("b start bit", 32'(tx_w[B]), 32'd0);
    end
  end

  task automatic push(input int k, input logic [8:0] d);
    @(negedge clk);
    din_r[k]   = d;
    start_r[k] = 1'b1;
    if (k != B) begin
      exp_q[k].push_back(d);
      exp_tot[k]++;
    end
    @(negedge clk);
    start_r[k] = 1'b0;
    din_r[k]   = 9'($urandom);
  endtask

  task automatic drain(input int k, input int lim);
    int c = 0;
    while (c < lim && (exp_q[k].size() != 0 || busy_w[k])) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("drain%0d in time", k), 32'(c < lim), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      din_r[k] = '0; start_r[k] = 1'b0;
      exp_tot[k] = 0; done_cnt[k] = 0; idle_bad[k] = 0;
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset tx%0d", k),    32'(tx_w[k]),   32'd1);
      chk($sformatf("reset busy%0d", k),  32'(busy_w[k]), 32'd0);
      chk($sformatf("reset done%0d", k),  32'(done_w[k]), 32'd0);
      chk($sformatf("reset ready%0d", k), 32'(rdy_w[k]),  32'd1);
      chk($sformatf("reset count%0d", k), 32'(cnt_w[k]),  32'd0);
    end
    repeat (10) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 10 * 1250; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (tx_w[k] !== 1'b1) idle_bad[k]++;
    end
    for (int k = 0; k < NI; k++) chk($sformatf("idle tx%0d glitches", k), 32'(idle_bad[k]), 32'd0);

    fork
      begin
        int j;
        push(0, 9'h0A5);
        j = 0;
        while (j < 13000 && !done_w[0]) begin
          @(negedge clk);
          j++;
        end
        chk("def tx_done latency", 32'(j), 32'd12501);
        drain(0, 2000);
      end
      begin
        int bc [5] = '{1, 1, 2, 3, 4};
        push(1, 9'h03C); drain(1, 200);
        push(1, 9'h007); drain(1, 200);
        push(2, 9'h03C); drain(2, 200);
        push(3, 9'h05A); drain(3, 400);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          din_r[B]   = 9'(17 * (i + 1));
          start_r[B] = 1'b1;
          @(negedge clk);
          chk($sformatf("burst count edge%0d", i), 32'(cnt_w[B]), 32'(bc[i]));
        end
        start_r[B] = 1'b0;
        chk("burst ready low", 32'(rdy_w[B]), 32'd0);
        drain(B, 1000);
        for (int i = 0; i < 400; i++) begin
          start_r[B] = ($urandom_range(0, 3) == 0);
          din_r[B]   = 9'($urandom);
          @(negedge clk);
        end
        start_r[B] = 1'b0;
        drain(B, 2000);
      end
    join

    push(B, 9'h03C);
    push(B, 9'h099);
    repeat (34) @(negedge clk);
    reset = 1'b1;
    exp_q[B].delete();
    #1;
    chk("midreset tx",    32'(tx_w[B]),   32'd1);
    chk("midreset count", 32'(cnt_w[B]),  32'd0);
    chk("midreset busy",  32'(busy_w[B]), 32'd0);
    chk("midreset ready", 32'(rdy_w[B]),  32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    push(B, 9'h0FF);
    drain(B, 400);

    for (int k = 0; k < NI - 1; k++)
      chk($sformatf("done pulses%0d", k), 32'(done_cnt[k]), 32'(exp_tot[k]));
    for (int k = 0; k < NI; k++)
      chk($sformatf("leftover frames%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format (data bits, parity, stop bits) and divisor derived from clock and baud parameters. It is the next generation of the plain 8N1 `uart_tx`. It sits between any byte producer in the 12 MHz iCESugar fabric and the board's TX pin, and accepts bursts without the producer waiting on each frame.

## Interface
Parameters:
- `CLK_FREQ`, 12000000: clock frequency in Hz.
- `BAUD`, 9600: line rate. `CLK_PER_BIT = CLK_FREQ / BAUD` uses integer division, giving 1250 at the defaults. Values below 2 are illegal.
- `DATA_BITS`, 8: payload width. The legal range is 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: number of entries. Must be a power of 2, at least 2.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input DATA_BITS: word to enqueue.
- `tx_start` input 1: write strobe. Sampled on each rising edge.
- `tx_ready` output 1: high when the FIFO is not full.
- `fifo_count` output $clog2(FIFO_DEPTH+1): number of entries queued, excluding the frame on the line.
- `tx` output 1: serial line, registered. Idle level is 1.
- `tx_busy` output 1: high whenever the FSM is not in IDLE.
- `tx_done` output 1: one-cycle pulse at the end of each frame.

## Operation
- **Reset values:** `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, `fifo_count`=0. The FIFO pointers clear.
- **Reset mid-frame:** the frame is aborted and `tx` goes high immediately, because reset is asynchronous. Queued data is discarded.
- **Push:** on an edge with `tx_start`=1 and `tx_ready`=1, `data_in` is written to the FIFO tail.
  - A push while full is dropped silently, even if a pop happens on the same edge.
  - A push and a pop on the same edge while not full are both performed, and `fifo_count` is unchanged.
- **Frame order:** start bit (0), then data LSB first, then the parity bit (if `PARITY`≠0), then `STOP_BITS` stop bits (1).
  - Frame length is `1 + DATA_BITS + (PARITY!=0) + STOP_BITS` bits, each exactly `CLK_PER_BIT` cycles.
- **Parity:** even parity = XOR of all data bits. Odd parity = the inverse of that.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. A bit counter and a baud counter are both internal.
  - IDLE → START on an edge where the FIFO is non-empty. On that edge the FSM pops the head into the shift register and drives `tx`<=0.
  - START → DATA after `CLK_PER_BIT` cycles.
  - DATA → PARITY, or → STOP when `PARITY`=0, after `DATA_BITS` bit periods.
  - PARITY → STOP after 1 bit period.
  - STOP ends after `STOP_BITS` bit periods. At that point `tx_done` pulses for 1 cycle and the FSM goes:
    - directly to START, popping the next word, if the FIFO is non-empty (no idle gap between frames);
    - otherwise to IDLE.
- **FIFO sampling:** `data_in` is captured into the FIFO at the push edge. Later changes to `data_in` do not affect queued frames.

## Timing
- **Start latency:** push at edge N; the FIFO is non-empty at edge N+1, where the pop happens and `tx` falls. This is 1 cycle of latency from the push edge.
- **Bit period:** each bit holds for exactly `CLK_PER_BIT` cycles. The default 8N1 frame is 12500 cycles.
- **`tx_done`:** high for exactly the 1 cycle following the edge that ends the last stop bit.
  - On a back-to-back frame, `tx` falls to 0 on that same edge.
- **`tx_busy`:** rises on the pop edge. It falls on the `tx_done` edge only when the FIFO is empty.
- **`tx_ready` and `fifo_count`:** update on the edge following a push or pop. No combinational path exists from `tx_start` to `tx_ready`.

## Test plan
- **Reset:** assert `reset` for 200 ns.
  - All outputs must hold their reset values.
  - `tx`=1 must hold for 10 bit periods after release with no push.
- **8N1, 0xA5:** sample `tx` at bit centres.
  - Required: 0, then 1,0,1,0,0,1,0,1, then 1.
  - `tx_done` pulses once, 12501 cycles after the push edge.
- **Parity:** 8E1 with 0x3C must give parity bit 0. 8O1 with 0x3C must give parity bit 1. Also check 8E1 with 0x07: parity bit 1.
- **Burst:** with FIFO_DEPTH=4, push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles.
  - `tx_ready` goes low after the fourth push counts against a full FIFO, so 0x55 is dropped only if the FIFO is full at that edge. Check `fifo_count` on every edge and verify the dropped-word count against it.
  - Frames must be contiguous: stop bit followed immediately by the next start bit, with no idle gap.
  - Expect one `tx_done` pulse per transmitted word.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x3C.
  - `tx`=1 immediately and `fifo_count`=0.
  - A subsequent push of 0xFF transmits cleanly.
- **Narrow config:** DATA_BITS=7, STOP_BITS=2, PARITY=1, CLK_FREQ=16, BAUD=1, sending 0x5A.
  - The frame is 11 bits × 16 cycles.
  - Required bits: 0, then 0,1,0,1,1,0,1, then parity 0, then 1,1.
